// File: rtl/msx_slot_access_ctrl.sv
// MSX slot access controller: resolves CPU accesses through primary/secondary slot state and an
// external layout table, then runs a single bounded memory cycle on behalf of the CPU.
module msx_slot_access_ctrl #(
  parameter int SLOTS    = 4,
  parameter int SUBSLOTS = 4,
  parameter int ADDR_W   = 27,
  parameter int TIMEOUT  = 255,
  localparam int SW      = $clog2(SLOTS),
  localparam int UW      = $clog2(SUBSLOTS),
  localparam int IW      = SW + UW + 2
) (
  input  logic              clk_sys_i,
  input  logic              reset_i,
  input  logic [15:0]       cpu_addr_i,
  input  logic [7:0]        cpu_data_in_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  output logic [7:0]        cpu_data_out_o,
  output logic              cpu_wait_o,
  output logic              cpu_done_o,
  input  logic [SW-1:0]     active_slot_i,
  input  logic [SLOTS-1:0]  expanded_i,
  output logic [IW-1:0]     lay_idx_o,
  input  logic              lay_valid_i,
  input  logic              lay_ro_i,
  input  logic [ADDR_W-1:0] lay_base_i,
  input  logic [15:0]       lay_blocks_i,
  input  logic [1:0]        lay_offset_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rnw_o,
  output logic [7:0]        mem_data_out_o,
  output logic              mem_req_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_data_in_i,
  output logic              timeout_err_o
);

  localparam int RW = 4 * UW;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_CHECK  = 3'd2,
    S_MEM    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  function automatic logic [UW-1:0] page_field(input logic [RW-1:0] r, input logic [1:0] pg);
    logic [UW-1:0] f;
    f = {UW{1'b0}};
    for (int p = 0; p < 4; p++) begin
      if (pg == 2'(p)) f = r[p*UW +: UW];
    end
    return f;
  endfunction

  // Subslot register reads back inverted, with bits beyond the register forced high.
  function automatic logic [7:0] ss_readback(input logic [RW-1:0] r);
    logic [7:0] v;
    v = 8'hFF;
    v[RW-1:0] = ~r;
    return v;
  endfunction

  state_e                    state_q, state_d;
  logic                      armed_q, armed_d;
  logic [13:0]               addr_q, addr_d;
  logic [7:0]                data_q, data_d;
  logic                      rnw_q, rnw_d;
  logic [SLOTS-1:0][RW-1:0]  ss_q, ss_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [IW-1:0]             lay_idx_q, lay_idx_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic                      mem_rnw_q, mem_rnw_d;
  logic [7:0]                mem_wdata_q, mem_wdata_d;
  logic                      mem_req_q, mem_req_d;
  logic [7:0]                cpu_rdata_q, cpu_rdata_d;
  logic                      cpu_wait_q, cpu_wait_d;
  logic                      cpu_done_q, cpu_done_d;
  logic                      terr_q, terr_d;

  logic                      accept_s;
  logic                      local_s;
  logic                      unmapped_s;
  logic [UW-1:0]             sub_s;
  logic [ADDR_W-1:0]         off_s;

  // armed_q blocks re-acceptance until the CPU has released both request lines.
  assign accept_s   = armed_q & (cpu_rd_i ^ cpu_wr_i);
  assign local_s    = (cpu_addr_i == 16'hFFFF) & expanded_i[active_slot_i];
  assign sub_s      = expanded_i[active_slot_i] ?
                      page_field(ss_q[active_slot_i], cpu_addr_i[15:14]) : {UW{1'b0}};
  assign unmapped_s = ~lay_valid_i | ({14'd0, lay_offset_i} >= lay_blocks_i);
  assign off_s      = ADDR_W'({lay_offset_i, addr_q});

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rnw_d       = rnw_q;
    ss_d        = ss_q;
    cnt_d       = cnt_q;
    lay_idx_d   = lay_idx_q;
    mem_addr_d  = mem_addr_q;
    mem_rnw_d   = mem_rnw_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    terr_d      = terr_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          addr_d = cpu_addr_i[13:0];
          data_d = cpu_data_in_i;
          rnw_d  = cpu_rd_i;
          if (local_s) begin
            if (cpu_wr_i) begin
              ss_d[active_slot_i] = cpu_data_in_i[RW-1:0];
            end else begin
              cpu_rdata_d = ss_readback(ss_q[active_slot_i]);
            end
            state_d = S_DONE;
          end else begin
            lay_idx_d = {active_slot_i, sub_s, cpu_addr_i[15:14]};
            state_d   = S_LOOKUP;
          end
        end else if (!cpu_rd_i && !cpu_wr_i) begin
          armed_d = 1'b1;
        end else begin
          armed_d = armed_q;
        end
      end
      S_LOOKUP: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (unmapped_s) begin
          if (rnw_q) begin
            cpu_rdata_d = 8'hFF;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
          state_d = S_DONE;
        end else if (!rnw_q && lay_ro_i) begin
          state_d = S_DONE;
        end else begin
          mem_addr_d  = lay_base_i + off_s;
          mem_rnw_d   = rnw_q;
          mem_wdata_d = data_q;
          cnt_d       = 16'd0;
          state_d     = S_MEM;
        end
      end
      S_MEM: begin
        if (mem_ack_i) begin
          if (rnw_q) begin
            cpu_rdata_d = mem_data_in_i;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          terr_d = 1'b1;
          if (rnw_q) begin
            cpu_rdata_d = 8'hFF;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        armed_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cpu_done_d = (state_d == S_DONE);
    cpu_wait_d = (state_d == S_LOOKUP) | (state_d == S_CHECK) | (state_d == S_MEM);
    mem_req_d  = (state_d == S_MEM);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b0;
      addr_q      <= 14'd0;
      data_q      <= 8'd0;
      rnw_q       <= 1'b1;
      ss_q        <= '0;
      cnt_q       <= 16'd0;
      lay_idx_q   <= {IW{1'b0}};
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_rnw_q   <= 1'b1;
      mem_wdata_q <= 8'd0;
      mem_req_q   <= 1'b0;
      cpu_rdata_q <= 8'd0;
      cpu_wait_q  <= 1'b0;
      cpu_done_q  <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rnw_q       <= rnw_d;
      ss_q        <= ss_d;
      cnt_q       <= cnt_d;
      lay_idx_q   <= lay_idx_d;
      mem_addr_q  <= mem_addr_d;
      mem_rnw_q   <= mem_rnw_d;
      mem_wdata_q <= mem_wdata_d;
      mem_req_q   <= mem_req_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_wait_q  <= cpu_wait_d;
      cpu_done_q  <= cpu_done_d;
      terr_q      <= terr_d;
    end
  end

  assign cpu_data_out_o = cpu_rdata_q;
  assign cpu_wait_o     = cpu_wait_q;
  assign cpu_done_o     = cpu_done_q;
  assign lay_idx_o      = lay_idx_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_rnw_o      = mem_rnw_q;
  assign mem_data_out_o = mem_wdata_q;
  assign mem_req_o      = mem_req_q;
  assign timeout_err_o  = terr_q;

endmodule

// File: tb/tb_msx_slot_access_ctrl.sv
// Scoreboard bench for msx_slot_access_ctrl: stimulus pushes expected access results, a
// monitor pops and compares them whenever cpu_done pulses.
module tb_msx_slot_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] cpu_addr_i;
  logic [7:0]  cpu_data_in_i;
  logic        cpu_rd_i, cpu_wr_i;
  logic [7:0]  cpu_data_out_o;
  logic        cpu_wait_o, cpu_done_o;
  logic [1:0]  active_slot_i;
  logic [3:0]  expanded_i;
  logic [5:0]  lay_idx_o;
  logic        lay_valid_i, lay_ro_i;
  logic [26:0] lay_base_i;
  logic [15:0] lay_blocks_i;
  logic [1:0]  lay_offset_i;
  logic [26:0] mem_addr_o;
  logic        mem_rnw_o;
  logic [7:0]  mem_data_out_o;
  logic        mem_req_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_in_i;
  logic        timeout_err_o;

  msx_slot_access_ctrl #(.SLOTS(4), .SUBSLOTS(4), .ADDR_W(27), .TIMEOUT(8)) dut (
    .clk_sys_i(clk), .reset_i(reset_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_in_i(cpu_data_in_i),
    .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i),
    .cpu_data_out_o(cpu_data_out_o), .cpu_wait_o(cpu_wait_o), .cpu_done_o(cpu_done_o),
    .active_slot_i(active_slot_i), .expanded_i(expanded_i),
    .lay_idx_o(lay_idx_o), .lay_valid_i(lay_valid_i), .lay_ro_i(lay_ro_i),
    .lay_base_i(lay_base_i), .lay_blocks_i(lay_blocks_i), .lay_offset_i(lay_offset_i),
    .mem_addr_o(mem_addr_o), .mem_rnw_o(mem_rnw_o), .mem_data_out_o(mem_data_out_o),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_data_in_i(mem_data_in_i),
    .timeout_err_o(timeout_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_data;
    logic [7:0]  data;
    int          waits;
    int          reqs;
    logic        chk_mem;
    logic [26:0] addr;
    logic        rnw;
    logic [7:0]  wdata;
    logic        chk_idx;
    logic [5:0]  idx;
    logic        terr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic cd, input logic [7:0] d, input int w, input int r,
                              input logic cm, input logic [26:0] a, input logic rnw,
                              input logic [7:0] wd, input logic ci, input logic [5:0] ix,
                              input logic te);
    exp_t e;
    e.chk_data = cd; e.data = d; e.waits = w; e.reqs = r;
    e.chk_mem = cm; e.addr = a; e.rnw = rnw; e.wdata = wd;
    e.chk_idx = ci; e.idx = ix; e.terr = te;
    return e;
  endfunction

  // Monitor: accumulates per-access observations, compares on every cpu_done pulse.
  initial begin
    int m_waits, m_reqs;
    logic [5:0] m_idx;
    logic [26:0] m_addr;
    logic m_rnw;
    logic [7:0] m_wdata;
    exp_t e;
    m_waits = 0; m_reqs = 0; m_idx = '0; m_addr = '0; m_rnw = 1'b1; m_wdata = '0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        m_waits = 0; m_reqs = 0;
      end else begin
        if (cpu_wait_o) begin
          if (m_waits == 0) m_idx = lay_idx_o;
          m_waits++;
        end
        if (mem_req_o) begin
          if (m_reqs == 0) begin
            m_addr = mem_addr_o; m_rnw = mem_rnw_o; m_wdata = mem_data_out_o;
          end
          m_reqs++;
        end
        if (cpu_done_o) begin
          done_cnt++;
          if (sb.size() == 0) begin
            chk("sb_unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("wait_cycles", m_waits, e.waits);
            chk("mem_req_cycles", m_reqs, e.reqs);
            chk("timeout_err", {31'd0, timeout_err_o}, {31'd0, e.terr});
            if (e.chk_data) chk("read_data", {24'd0, cpu_data_out_o}, {24'd0, e.data});
            if (e.chk_idx) chk("lay_idx", {26'd0, m_idx}, {26'd0, e.idx});
            if (e.chk_mem) begin
              chk("mem_addr", {5'd0, m_addr}, {5'd0, e.addr});
              chk("mem_rnw", {31'd0, m_rnw}, {31'd0, e.rnw});
              if (!e.rnw) chk("mem_wdata", {24'd0, m_wdata}, {24'd0, e.wdata});
            end
          end
          m_waits = 0; m_reqs = 0;
        end
      end
    end
  end

  task automatic set_lay(input logic v, input logic ro, input logic [26:0] base,
                         input logic [15:0] blocks, input logic [1:0] off);
    lay_valid_i = v; lay_ro_i = ro; lay_base_i = base; lay_blocks_i = blocks; lay_offset_i = off;
  endtask

  task automatic do_access(input logic rd, input logic [15:0] a, input logic [7:0] d,
                           input logic [1:0] slot, input exp_t e, input int hold);
    bit seen;
    int snap;
    sb.push_back(e);
    cpu_addr_i = a; cpu_data_in_i = d; active_slot_i = slot;
    cpu_rd_i = rd; cpu_wr_i = ~rd;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (cpu_done_o) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    if (hold > 0) begin
      @(negedge clk);
      snap = done_cnt;
      repeat (hold) @(negedge clk);
      chk("hold_no_wait", {31'd0, cpu_wait_o}, 32'd0);
      chk("hold_no_redo", done_cnt, snap);
    end
    cpu_rd_i = 1'b0; cpu_wr_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    reset_i = 1'b1; cpu_addr_i = 16'h0000; cpu_data_in_i = 8'h00;
    cpu_rd_i = 1'b0; cpu_wr_i = 1'b0; active_slot_i = 2'd0; expanded_i = 4'b0000;
    set_lay(1'b0, 1'b0, 27'h0, 16'h0, 2'd0);
    mem_ack_i = 1'b1; mem_data_in_i = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cpu_wait", {31'd0, cpu_wait_o}, 32'd0);
    chk("rst_cpu_done", {31'd0, cpu_done_o}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_rnw", {31'd0, mem_rnw_o}, 32'd1);
    chk("rst_cpu_data", {24'd0, cpu_data_out_o}, 32'd0);
    chk("rst_lay_idx", {26'd0, lay_idx_o}, 32'd0);
    chk("rst_mem_addr", {5'd0, mem_addr_o}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err_o}, 32'd0);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);

    // Subslot register write/readback on expanded slot 3.
    expanded_i = 4'b1000;
    do_access(1'b0, 16'hFFFF, 8'hA4, 2'd3, mk(0, 8'h00, 0, 0, 0, 27'h0, 1, 8'h00, 0, 6'h0, 0), 0);
    do_access(1'b1, 16'hFFFF, 8'h00, 2'd3, mk(1, 8'h5B, 0, 0, 0, 27'h0, 1, 8'h00, 0, 6'h0, 0), 0);

    // Mapped read, unexpanded slot 1, immediate ack.
    set_lay(1'b1, 1'b0, 27'h100000, 16'd2, 2'd1);
    mem_data_in_i = 8'h3C;
    do_access(1'b1, 16'h4123, 8'h00, 2'd1,
              mk(1, 8'h3C, 3, 1, 1, 27'h104123, 1, 8'h00, 1, 6'h11, 0), 0);

    // Expanded slot 3, page 2 selects subslot 2; address wraps at 27 bits.
    set_lay(1'b1, 1'b0, 27'h7FFC000, 16'd4, 2'd1);
    mem_data_in_i = 8'h5A;
    do_access(1'b1, 16'h8005, 8'h00, 2'd3,
              mk(1, 8'h5A, 3, 1, 1, 27'h0000005, 1, 8'h00, 1, 6'h3A, 0), 0);

    // Mapped write.
    set_lay(1'b1, 1'b0, 27'h200, 16'd1, 2'd0);
    do_access(1'b0, 16'h0010, 8'h77, 2'd0,
              mk(0, 8'h00, 3, 1, 1, 27'h210, 0, 8'h77, 1, 6'h00, 0), 0);

    // Read-only write, out-of-range read, unmapped read: no memory cycle.
    set_lay(1'b1, 1'b1, 27'h300, 16'd1, 2'd0);
    do_access(1'b0, 16'h4000, 8'h11, 2'd1, mk(0, 8'h00, 2, 0, 0, 27'h0, 1, 8'h00, 1, 6'h11, 0), 0);
    set_lay(1'b1, 1'b0, 27'h300, 16'd2, 2'd2);
    do_access(1'b1, 16'hC000, 8'h00, 2'd2, mk(1, 8'hFF, 2, 0, 0, 27'h0, 1, 8'h00, 1, 6'h23, 0), 0);
    set_lay(1'b0, 1'b0, 27'h300, 16'd4, 2'd0);
    do_access(1'b1, 16'h2000, 8'h00, 2'd0, mk(1, 8'hFF, 2, 0, 0, 27'h0, 1, 8'h00, 1, 6'h00, 0), 0);

    // Both request lines high: nothing accepted.
    snap = done_cnt;
    cpu_addr_i = 16'h4123; active_slot_i = 2'd1; cpu_rd_i = 1'b1; cpu_wr_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("both_no_wait", {31'd0, cpu_wait_o}, 32'd0);
    chk("both_no_done", done_cnt, snap);
    cpu_rd_i = 1'b0; cpu_wr_i = 1'b0;
    repeat (2) @(negedge clk);

    // Request held after completion must not start a second access.
    do_access(1'b1, 16'hFFFF, 8'h00, 2'd3, mk(1, 8'h5B, 0, 0, 0, 27'h0, 1, 8'h00, 0, 6'h0, 0), 4);

    // Timeout: no ack for TIMEOUT=8 cycles.
    set_lay(1'b1, 1'b0, 27'h100000, 16'd2, 2'd1);
    mem_ack_i = 1'b0; mem_data_in_i = 8'h96;
    do_access(1'b1, 16'h4123, 8'h00, 2'd1,
              mk(1, 8'hFF, 10, 8, 1, 27'h104123, 1, 8'h00, 1, 6'h11, 1), 0);
    mem_ack_i = 1'b1;
    do_access(1'b1, 16'h4123, 8'h00, 2'd1,
              mk(1, 8'h96, 3, 1, 1, 27'h104123, 1, 8'h00, 1, 6'h11, 1), 0);

    // Reset in the middle of a memory cycle, followed by a late ack.
    mem_ack_i = 1'b0;
    snap = done_cnt;
    cpu_addr_i = 16'h4123; active_slot_i = 2'd1; cpu_rd_i = 1'b1; cpu_wr_i = 1'b0;
    for (int k = 0; k < 20 && !mem_req_o; k++) @(negedge clk);
    chk("rst_mid_mem_seen", {31'd0, mem_req_o}, 32'd1);
    repeat (2) @(negedge clk);
    reset_i = 1'b1; cpu_rd_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req", {31'd0, mem_req_o}, 32'd0);
    mem_ack_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_late_ack_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_late_ack_wait", {31'd0, cpu_wait_o}, 32'd0);
    chk("rst_no_done", done_cnt, snap);
    chk("rst_terr_clear", {31'd0, timeout_err_o}, 32'd0);

    // Subslot registers cleared by reset.
    do_access(1'b1, 16'hFFFF, 8'h00, 2'd3, mk(1, 8'hFF, 0, 0, 0, 27'h0, 1, 8'h00, 0, 6'h0, 0), 0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
